// File: rtl/mahjong_keymatrix.sv
// -----------------------------------------------------------------------------
// mahjong_keymatrix
//
// Turns PS/2 key events into the row-scanned mahjong control panel that the
// game core reads. The core strobes mux_clock to step through the rows. For
// each row it reads an active-low byte of key states (inp0) and a one-hot row
// strobe (inp1).
//
// Parameters
//   NUM_ROWS           rows scanned, 1..7 (row index 0..NUM_ROWS-1)
//   AUTORELEASE_CYCLES idle cycles before held keys are force-released
//                      (only used when the macro below is defined)
//
// Build option
//   MAHJONG_KEYMATRIX_AUTORELEASE_EN  when defined, clears every held key once
//                      keys have been held for AUTORELEASE_CYCLES cycles with
//                      no PS/2 event. When undefined, keys stay held until
//                      their break code arrives or reset is applied.
//
// Ports
//   clk_sys    in   system clock, all state on the rising edge
//   reset_n    in   asynchronous active-low reset
//   ps2_key    in   [10] event toggle, [9] pressed, [8:0] scan code (bit 8 = E0)
//   start_any  in   start1|start2 level, shown live on row 6 bit 0
//   mux_clock  in   row-advance strobe; each rising edge selects the next row
//   enable     in   panel in use; when low, scanning freezes and outputs idle
//   sync       in   single-cycle request to reload the row from init_row
//   init_row   in   row loaded at reset and on sync (>= NUM_ROWS loads 0)
//   row_sel    out  current scanned row
//   inp0       out  active-low key bits of the current row (registered)
//   inp1       out  one-hot row strobe, bit 7 always 0
//   key_evt    out  one-cycle pulse after any mapped key bit changes
// -----------------------------------------------------------------------------
module mahjong_keymatrix #(
   parameter int NUM_ROWS           = 7,
   parameter int AUTORELEASE_CYCLES = 40000000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic        start_any,
   input  logic        mux_clock,
   input  logic        enable,
   input  logic        sync,
   input  logic [2:0]  init_row,
   output logic [2:0]  row_sel,
   output logic [7:0]  inp0,
   output logic [7:0]  inp1,
   output logic        key_evt
);

   // The matrix is indexed directly by the 3-bit row. Rows >= NUM_ROWS are
   // never selected, so their storage falls away in synthesis.
   localparam int         MAT_ROWS = 8;
   localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);
   localparam logic [6:0] ROW_MASK = 7'((1 << NUM_ROWS) - 1);

   // init_row values outside the scanned range start at row 0.
   function automatic logic [2:0] clamp_row(input logic [2:0] r);
      return (32'(r) < NUM_ROWS) ? r : 3'd0;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic                         primed_q;      // low for the first cycle after reset
   logic                         ps2_tog_q;     // ps2_key[10] from the previous cycle
   logic                         mux_q;         // mux_clock from the previous cycle
   logic [MAT_ROWS-1:0][7:0]     matrix_q, matrix_d;
   logic [2:0]                   row_q, row_d;
   logic [6:0]                   strobe_q, strobe_d;
   logic [7:0]                   inp0_q, inp0_d;
   logic                         chg_q, chg_d;  // matrix changed at the last edge
   logic                         key_evt_q;

   // ---------------------------------------------------------------------------
   // Edge detection
   // ---------------------------------------------------------------------------
   // Both registered copies pick up the live inputs on the first cycle after
   // reset. primed_q masks that cycle, so a toggle bit or strobe that is
   // already high at reset release does not count as an event.
   logic ps2_evt;
   logic mux_rise;

   assign ps2_evt  = primed_q & (ps2_key[10] ^ ps2_tog_q);
   assign mux_rise = primed_q & mux_clock & ~mux_q;

   // ---------------------------------------------------------------------------
   // Scan-code to matrix position
   // ---------------------------------------------------------------------------
   logic       map_hit;
   logic [2:0] map_row;
   logic [2:0] map_bit;

   always_comb begin
      // NOTE: every signal written in a combinational block gets a default
      // first. Otherwise a path that leaves it unassigned infers a latch.
      map_hit = 1'b1;
      map_row = 3'd0;
      map_bit = 3'd0;
      case (ps2_key[8:0])
         9'h01C: begin map_row = 3'd2; map_bit = 3'd0; end
         9'h032: begin map_row = 3'd2; map_bit = 3'd1; end
         9'h021: begin map_row = 3'd2; map_bit = 3'd2; end
         9'h023: begin map_row = 3'd2; map_bit = 3'd3; end
         9'h111: begin map_row = 3'd2; map_bit = 3'd4; end
         9'h024: begin map_row = 3'd3; map_bit = 3'd0; end
         9'h02B: begin map_row = 3'd3; map_bit = 3'd1; end
         9'h034: begin map_row = 3'd3; map_bit = 3'd2; end
         9'h033: begin map_row = 3'd3; map_bit = 3'd3; end
         9'h043: begin map_row = 3'd4; map_bit = 3'd0; end
         9'h03B: begin map_row = 3'd4; map_bit = 3'd1; end
         9'h042: begin map_row = 3'd4; map_bit = 3'd2; end
         9'h04B: begin map_row = 3'd4; map_bit = 3'd3; end
         9'h03A: begin map_row = 3'd5; map_bit = 3'd0; end
         9'h031: begin map_row = 3'd5; map_bit = 3'd1; end
         9'h029: begin map_row = 3'd5; map_bit = 3'd2; end
         9'h011: begin map_row = 3'd5; map_bit = 3'd3; end
         9'h035: begin map_row = 3'd5; map_bit = 3'd4; end
         9'h026: begin map_row = 3'd6; map_bit = 3'd1; end
         9'h014: begin map_row = 3'd0; map_bit = 3'd0; end
         9'h012: begin map_row = 3'd0; map_bit = 3'd1; end
         9'h01A: begin map_row = 3'd0; map_bit = 3'd2; end
         default: map_hit = 1'b0;
      endcase
   end

   // A repeated make of a key that is already held leaves the bit unchanged,
   // so it produces no key_evt.
   logic key_chg;
   assign key_chg = ps2_evt & map_hit & (matrix_q[map_row][map_bit] != ps2_key[9]);

   // ---------------------------------------------------------------------------
   // Optional auto-release
   // ---------------------------------------------------------------------------
`ifdef MAHJONG_KEYMATRIX_AUTORELEASE_EN
   localparam int CNT_W = $clog2(AUTORELEASE_CYCLES + 1);

   logic             any_held;
   logic             ar_fire;
   logic [CNT_W-1:0] ar_cnt_q, ar_cnt_d;

   assign any_held = |matrix_q;

   // The counter runs only while a key is held and the PS/2 stream is quiet.
   // The cycle that brings the count to AUTORELEASE_CYCLES clears the matrix.
   always_comb begin
      ar_fire  = 1'b0;
      ar_cnt_d = ar_cnt_q;
      if (ps2_evt || !any_held) begin
         ar_cnt_d = '0;
      end else if (ar_cnt_q == CNT_W'(AUTORELEASE_CYCLES - 1)) begin
         ar_fire  = 1'b1;
         ar_cnt_d = '0;
      end else begin
         ar_cnt_d = ar_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) ar_cnt_q <= '0;
      else          ar_cnt_q <= ar_cnt_d;
   end
`else
   logic ar_fire;
   assign ar_fire = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Matrix update
   // ---------------------------------------------------------------------------
   // ar_fire only occurs in a cycle with no PS/2 event, so the two branches
   // never compete.
   always_comb begin
      matrix_d = matrix_q;
      chg_d    = 1'b0;
      if (ar_fire) begin
         matrix_d = '0;
         chg_d    = 1'b1;
      end else if (key_chg) begin
         matrix_d[map_row][map_bit] = ps2_key[9];
         chg_d                      = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Row scanning
   // ---------------------------------------------------------------------------
   // sync takes priority over a mux_clock edge in the same cycle. When
   // disabled, the scan position stays frozen. The strobe rotates only within
   // the low NUM_ROWS bits, so the top row wraps back to bit 0.
   always_comb begin
      row_d    = row_q;
      strobe_d = strobe_q;
      if (sync) begin
         row_d    = clamp_row(init_row);
         strobe_d = 7'd1 << row_d;
      end else if (mux_rise && enable) begin
         row_d    = (row_q == LAST_ROW) ? 3'd0 : row_q + 3'd1;
         strobe_d = ((strobe_q << 1) & ROW_MASK) | {6'd0, strobe_q[NUM_ROWS-1]};
      end
   end

   // ---------------------------------------------------------------------------
   // Row read-out
   // ---------------------------------------------------------------------------
   // Row 6 bit 0 is not stored: it comes straight from start_any. Bits with no
   // key mapped to them stay 0 in the matrix, so they read back as 1.
   logic [7:0] row_bits;

   always_comb begin
      row_bits = matrix_q[row_q];
      if (row_q == 3'd6) row_bits[0] = start_any;
      inp0_d = ~row_bits;
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // Reset reloads the scan position from init_row, so a reset in the middle of
   // a scan discards the previous position.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         primed_q  <= 1'b0;
         ps2_tog_q <= 1'b0;
         mux_q     <= 1'b0;
         matrix_q  <= '0;
         row_q     <= clamp_row(init_row);
         strobe_q  <= 7'd1 << clamp_row(init_row);
         inp0_q    <= 8'hFF;
         chg_q     <= 1'b0;
         key_evt_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments. Every register
         // then sees the pre-edge value of every other register.
         primed_q  <= 1'b1;
         ps2_tog_q <= ps2_key[10];
         mux_q     <= mux_clock;
         matrix_q  <= matrix_d;
         row_q     <= row_d;
         strobe_q  <= strobe_d;
         inp0_q    <= inp0_d;
         chg_q     <= chg_d;
         key_evt_q <= chg_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // When disabled, the panel reads idle. Key tracking and inp0_q keep running,
   // so the correct byte appears as soon as enable returns.
   assign row_sel = row_q;
   assign inp0    = enable ? inp0_q : 8'hFF;
   assign inp1    = enable ? {1'b0, strobe_q} : 8'h00;
   assign key_evt = key_evt_q;

endmodule

// File: tb/tb_mahjong_keymatrix.sv
// -----------------------------------------------------------------------------
// tb_mahjong_keymatrix
//
// Self-checking bench for mahjong_keymatrix. A reference model tracks the set
// of held keys by scan code, together with the scan row as an integer. Each
// DUT output is compared against that model once per cycle, on the falling
// clock edge. Directed scenarios cover the documented corner cases; a
// randomized phase with a mid-scan reset follows.
// -----------------------------------------------------------------------------
module tb_mahjong_keymatrix;

   localparam int NUM_ROWS  = 7;
   localparam int AR_CYCLES = 100;
   localparam int NKEYS     = 22;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [10:0] ps2_key;
   logic        start_any;
   logic        mux_clock;
   logic        enable;
   logic        sync;
   logic [2:0]  init_row;
   logic [2:0]  row_sel;
   logic [7:0]  inp0;
   logic [7:0]  inp1;
   logic        key_evt;

   always #5 clk_sys = ~clk_sys;

   mahjong_keymatrix #(
      .NUM_ROWS           (NUM_ROWS),
      .AUTORELEASE_CYCLES (AR_CYCLES)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .ps2_key   (ps2_key),
      .start_any (start_any),
      .mux_clock (mux_clock),
      .enable    (enable),
      .sync      (sync),
      .init_row  (init_row),
      .row_sel   (row_sel),
      .inp0      (inp0),
      .inp1      (inp1),
      .key_evt   (key_evt)
   );

   // ---------------------------------------------------------------------------
   // Key map: scan code -> (row, bit)
   // ---------------------------------------------------------------------------
   logic [8:0] key_code [NKEYS] = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h111,
                                    9'h024, 9'h02B, 9'h034, 9'h033,
                                    9'h043, 9'h03B, 9'h042, 9'h04B,
                                    9'h03A, 9'h031, 9'h029, 9'h011, 9'h035,
                                    9'h026,
                                    9'h014, 9'h012, 9'h01A};
   int key_row [NKEYS] = '{2, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4,
                           5, 5, 5, 5, 5, 6, 0, 0, 0};
   int key_bit [NKEYS] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 0, 1, 2, 3,
                           0, 1, 2, 3, 4, 1, 0, 1, 2};

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   bit         held_m [NKEYS];
   int         row_m;
   logic [7:0] inp0_m;
   bit         kevt_m, chg_m, primed_m, tog_m, mux_m;
   int         cnt_m;

   function automatic int find_key(input logic [8:0] c);
      for (int i = 0; i < NKEYS; i++) if (key_code[i] == c) return i;
      return -1;
   endfunction

   function automatic int clamp(input logic [2:0] r);
      return (int'(r) < NUM_ROWS) ? int'(r) : 0;
   endfunction

   function automatic logic [7:0] row_image(input int r, input bit start);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < NKEYS; i++)
         if (held_m[i] && key_row[i] == r) b = b | (8'd1 << key_bit[i]);
      if (r == 6 && start) b = b | 8'h01;
      return ~b;
   endfunction

   task automatic model_reset();
      foreach (held_m[i]) held_m[i] = 1'b0;
      row_m    = clamp(init_row);
      inp0_m   = 8'hFF;
      kevt_m   = 1'b0;
      chg_m    = 1'b0;
      primed_m = 1'b0;
      tog_m    = 1'b0;
      mux_m    = 1'b0;
      cnt_m    = 0;
   endtask

   // Model state at each rising edge, computed from the inputs as they were
   // before the edge.
   task automatic model_edge();
      logic [7:0] nxt_inp0;
      bit         evt, rise, chg, any;
      int         k;
      if (!reset_n) begin
         model_reset();
         return;
      end
      nxt_inp0 = row_image(row_m, start_any);
      evt      = primed_m && (ps2_key[10] != tog_m);
      rise     = primed_m && mux_clock && !mux_m;
      any      = 1'b0;
      foreach (held_m[i]) any |= held_m[i];
      chg = 1'b0;
      k   = find_key(ps2_key[8:0]);
      if (evt && k >= 0 && held_m[k] != ps2_key[9]) begin
         held_m[k] = ps2_key[9];
         chg       = 1'b1;
      end
`ifdef MAHJONG_KEYMATRIX_AUTORELEASE_EN
      if (evt || !any) begin
         cnt_m = 0;
      end else begin
         cnt_m++;
         if (cnt_m == AR_CYCLES) begin
            foreach (held_m[i]) held_m[i] = 1'b0;
            chg   = 1'b1;
            cnt_m = 0;
         end
      end
`endif
      if (sync)                 row_m = clamp(init_row);
      else if (rise && enable)  row_m = (row_m + 1) % NUM_ROWS;
      kevt_m   = chg_m;
      chg_m    = chg;
      inp0_m   = nxt_inp0;
      tog_m    = ps2_key[10];
      mux_m    = mux_clock;
      primed_m = 1'b1;
   endtask

   task automatic compare_all(input string ph);
      logic [7:0] want_inp1;
      want_inp1 = enable ? 8'((1 << row_m) & 8'h7F) : 8'h00;
      check({ph, ".row_sel"}, row_sel, row_m);
      check({ph, ".inp1"},    inp1,    want_inp1);
      check({ph, ".inp0"},    inp0,    enable ? inp0_m : 8'hFF);
      check({ph, ".key_evt"}, key_evt, kevt_m);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         model_edge();
         @(negedge clk_sys);
         compare_all("cyc");
      end
   endtask

   task automatic ps2_send(input logic [8:0] code, input logic pressed);
      ps2_key = {~ps2_key[10], pressed, code};
   endtask

   task automatic do_sync(input logic [2:0] r);
      init_row = r;
      sync     = 1'b1;
      tick(1);
      sync     = 1'b0;
      tick(1);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   int pulses;

   initial begin
      // The toggle bit is already high, with a mapped make code, when reset is
      // released. That must not count as an event.
      reset_n   = 1'b0;
      ps2_key   = {1'b1, 1'b1, 9'h01C};
      start_any = 1'b0;
      mux_clock = 1'b0;
      enable    = 1'b1;
      sync      = 1'b0;
      init_row  = 3'd3;
      model_reset();
      tick(2);
      check("rst.row_sel", row_sel, 3);
      check("rst.inp1",    inp1,    8'h08);
      check("rst.inp0",    inp0,    8'hFF);
      check("rst.key_evt", key_evt, 0);

      reset_n = 1'b1;
      tick(4);
      check("release.no_evt", key_evt, 0);
      check("release.row",    row_sel, 3);

      // Press and break 0x1C on row 2; a repeated make gives no pulse.
      do_sync(3'd2);
      ps2_send(9'h01C, 1'b1);
      tick(2);
      check("press1c.inp0", inp0,    8'hFE);
      check("press1c.evt",  key_evt, 1);
      tick(1);
      check("press1c.evt_end", key_evt, 0);
      ps2_send(9'h01C, 1'b1);
      tick(3);
      ps2_send(9'h01C, 1'b0);
      tick(2);
      check("break1c.inp0", inp0, 8'hFF);

      // Wrap from row 6; a held strobe advances only once.
      do_sync(3'd6);
      mux_clock = 1'b1;
      tick(1);
      check("wrap.row_sel", row_sel, 0);
      check("wrap.inp1",    inp1,    8'h01);
      tick(9);
      check("held_mux.row_sel", row_sel, 0);
      mux_clock = 1'b0;
      tick(1);

      // sync with out-of-range row beats a concurrent strobe edge.
      do_sync(3'd3);
      init_row  = 3'd7;
      sync      = 1'b1;
      mux_clock = 1'b1;
      tick(1);
      check("sync7.row_sel", row_sel, 0);
      check("sync7.inp1",    inp1,    8'h01);
      sync      = 1'b0;
      mux_clock = 1'b0;
      tick(2);

      // Key event and row advance in the same cycle.
      do_sync(3'd6);
      ps2_send(9'h014, 1'b1);
      mux_clock = 1'b1;
      tick(2);
      check("concurrent.inp0", inp0,    8'hFE);
      check("concurrent.row",  row_sel, 0);
      mux_clock = 1'b0;
      ps2_send(9'h014, 1'b0);
      tick(2);

      // enable=0 freezes scanning and idles the outputs.
      do_sync(3'd5);
      ps2_send(9'h029, 1'b1);
      tick(3);
      check("hold29.inp0", inp0, 8'hFB);
      enable = 1'b0;
      tick(2);
      check("disabled.inp0", inp0, 8'hFF);
      check("disabled.inp1", inp1, 8'h00);
      repeat (3) begin
         mux_clock = 1'b1;
         tick(1);
         mux_clock = 1'b0;
         tick(1);
      end
      check("disabled.row", row_sel, 5);
      enable = 1'b1;
      tick(1);
      check("reenable.inp0", inp0, 8'hFB);
      check("reenable.inp1", inp1, 8'h20);
      ps2_send(9'h029, 1'b0);
      tick(2);

      // Hold 0x111 on row 2 well past the auto-release interval.
      do_sync(3'd2);
      ps2_send(9'h111, 1'b1);
      pulses = 0;
      for (int c = 0; c < AR_CYCLES + 30; c++) begin
         tick(1);
         if (key_evt === 1'b1) pulses++;
      end
`ifdef MAHJONG_KEYMATRIX_AUTORELEASE_EN
      check("autorelease.inp0",   inp0,   8'hFF);
      check("autorelease.pulses", pulses, 2);
`else
      check("held111.inp0",   inp0,   8'hEF);
      check("held111.pulses", pulses, 1);
`endif
      ps2_send(9'h111, 1'b0);
      tick(2);

      // Randomized traffic with a mid-scan reset.
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            mux_clock = 1'b0;
            sync      = 1'b0;
            init_row  = 3'd7;
            reset_n   = 1'b0;
            model_reset();
            #1;
            compare_all("midrst");
            tick(2);
            reset_n = 1'b1;
            tick(1);
         end
         if ($urandom_range(3) == 0) begin
            if ($urandom_range(9) < 8) ps2_send(key_code[$urandom_range(NKEYS - 1)], 1'($urandom_range(1)));
            else                       ps2_send(9'($urandom_range(511)), 1'($urandom_range(1)));
         end
         if ($urandom_range(2) == 0) mux_clock = ~mux_clock;
         sync      = ($urandom_range(40) == 0);
         init_row  = 3'($urandom_range(7));
         enable    = ($urandom_range(15) != 0);
         start_any = 1'($urandom_range(1));
         tick(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
